// File: rtl/bp_fpga_host_io_tester.sv
// bp_fpga_host_io_tester
// ----------------------
// Board bring-up traffic generator and loopback for bp_fpga_host, used
// without a BlackParrot core attached.
//
// Generator: a debounced button press fires a burst of putchar uncached
// writes into the host. The number of outstanding writes is bounded, and
// every write carries the next value of an incrementing byte.
//
// Loopback: IO commands issued by the host come back as responses through
// a small FIFO.
//
// Ports
//   clk_i, reset_n_i          clock, asynchronous active-low reset
//   send_i                    raw button level (asynchronous to clk_i)
//   io_cmd_o/_v_o/_ready_and_i    generated write commands to the host
//   io_resp_i/_v_i/_yumi_o        write acknowledgements from the host
//   lb_cmd_i/_v_i/_yumi_o         host-issued commands to loop back
//   lb_resp_o/_v_o/_ready_and_i   looped-back responses to the host
//   busy_o, done_o, error_o, resp_count_o   status for LEDs and the ILA
//
// Optional build macro BP_FPGA_HOST_IO_TESTER_CHECK_EN:
//   When defined, every acknowledgement header is checked against the
//   write that was issued. A mismatch sets error_o.
//   When undefined, the acknowledgement payload is ignored.
//
// The bedrock IO message layout below is a local copy for the default
// configuration (40-bit physical address, 64-bit data).

package bp_fpga_host_io_tester_pkg;

  localparam int paddr_width_gp   = 40;
  localparam int io_data_width_gp = 64;

  typedef enum logic [0:0] {e_bp_default_cfg = 1'b0} bp_params_e;

  function automatic int bp_paddr_width(input bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return paddr_width_gp;
      default:          return paddr_width_gp;
    endcase
  endfunction

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3,
    e_bedrock_mem_amo   = 4'd4
  } bp_bedrock_mem_type_e;

  typedef enum logic [3:0] {
    e_bedrock_store   = 4'd0,
    e_bedrock_amoswap = 4'd1,
    e_bedrock_amoadd  = 4'd2
  } bp_bedrock_wr_subop_e;

  typedef enum logic [2:0] {
    e_bedrock_msg_size_1 = 3'd0,
    e_bedrock_msg_size_2 = 3'd1,
    e_bedrock_msg_size_4 = 3'd2,
    e_bedrock_msg_size_8 = 3'd3
  } bp_bedrock_msg_size_e;

  typedef struct packed {
    logic [7:0]                payload;
    bp_bedrock_msg_size_e      size;
    logic [paddr_width_gp-1:0] addr;
    bp_bedrock_wr_subop_e      subop;
    bp_bedrock_mem_type_e      msg_type;
  } bp_bedrock_io_mem_header_s;

  typedef struct packed {
    logic [io_data_width_gp-1:0] data;
    bp_bedrock_io_mem_header_s   header;
  } bp_bedrock_io_mem_msg_s;

  localparam int io_msg_width_gp = $bits(bp_bedrock_io_mem_msg_s);

endpackage

module bp_fpga_host_io_tester
  import bp_fpga_host_io_tester_pkg::*;
  #(parameter bp_params_e bp_params_p = e_bp_default_cfg
   ,localparam int paddr_width_p = bp_paddr_width(bp_params_p)
   ,parameter logic [paddr_width_p-1:0] putchar_addr_p = paddr_width_p'(64'h0010_1000)
   ,parameter int burst_len_p       = 16
   ,parameter int max_outstanding_p = 4
   ,parameter int debounce_cycles_p = 1000000
   ,parameter int loopback_els_p    = 2
   ,parameter logic [7:0] init_byte_p = 8'h00
   )
  (input  logic                       clk_i
  ,input  logic                       reset_n_i
  ,input  logic                       send_i
  ,output logic [io_msg_width_gp-1:0] io_cmd_o
  ,output logic                       io_cmd_v_o
  ,input  logic                       io_cmd_ready_and_i
  ,input  logic [io_msg_width_gp-1:0] io_resp_i
  ,input  logic                       io_resp_v_i
  ,output logic                       io_resp_yumi_o
  ,input  logic [io_msg_width_gp-1:0] lb_cmd_i
  ,input  logic                       lb_cmd_v_i
  ,output logic                       lb_cmd_yumi_o
  ,output logic [io_msg_width_gp-1:0] lb_resp_o
  ,output logic                       lb_resp_v_o
  ,input  logic                       lb_resp_ready_and_i
  ,output logic                       busy_o
  ,output logic                       done_o
  ,output logic                       error_o
  ,output logic [15:0]                resp_count_o
  );

  localparam int db_width_lp  = (debounce_cycles_p > 1) ? $clog2(debounce_cycles_p) : 1;
  localparam logic [db_width_lp-1:0] db_max_lp = db_width_lp'(debounce_cycles_p - 1);
  localparam int cred_width_lp = $clog2(max_outstanding_p + 1);
  localparam int lb_ptr_w_lp   = (loopback_els_p > 1) ? $clog2(loopback_els_p) : 1;
  localparam int lb_cnt_w_lp   = $clog2(loopback_els_p + 1);

  typedef enum logic [1:0] {e_idle, e_send, e_drain} state_e;

  // Button synchroniser and debouncer. The counter restarts on every change
  // of the synchronised level. A level is accepted only after it has been
  // stable long enough. The start pulse is the rising edge of the accepted
  // level.
  logic                   send_sync1_r, send_sync2_r, send_last_r;
  logic                   send_stable_r, send_stable_last_r;
  logic [db_width_lp-1:0] db_cnt_r;
  logic                   start;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      send_sync1_r       <= 1'b0;
      send_sync2_r       <= 1'b0;
      send_last_r        <= 1'b0;
      send_stable_r      <= 1'b0;
      send_stable_last_r <= 1'b0;
      db_cnt_r           <= '0;
    end else begin
      send_sync1_r       <= send_i;
      send_sync2_r       <= send_sync1_r;
      send_last_r        <= send_sync2_r;
      send_stable_last_r <= send_stable_r;
      if (send_sync2_r != send_last_r) begin
        db_cnt_r <= '0;
      end else begin
        if (db_cnt_r != db_max_lp) begin
          db_cnt_r <= db_cnt_r + 1'b1;
        end
        if (db_cnt_r == db_max_lp) begin
          send_stable_r <= send_sync2_r;
        end
      end
    end
  end

  assign start = send_stable_r & ~send_stable_last_r;

  // Generator state
  state_e                   state_r, state_n;
  logic [7:0]               byte_r;
  logic [15:0]              sent_cnt_r;
  logic [cred_width_lp-1:0] credits_r, credits_n;
  logic [15:0]              resp_count_r;
  logic                     error_r;
  logic                     cmd_fire, ack, ack_bad, clear_sent, done;

  assign io_cmd_v_o     = (state_r == e_send) && (credits_r < cred_width_lp'(max_outstanding_p));
  assign cmd_fire       = io_cmd_v_o & io_cmd_ready_and_i;
  assign ack            = io_resp_v_i;
  assign io_resp_yumi_o = io_resp_v_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= e_idle;
    end else begin
      state_r <= state_n;
    end
  end

  // Next state and burst bookkeeping strobes. Start pulses are ignored
  // outside e_idle.
  always_comb begin
    state_n    = state_r;
    clear_sent = 1'b0;
    done       = 1'b0;
    case (state_r)
      e_idle: begin
        if (start) begin
          state_n    = e_send;
          clear_sent = 1'b1;
        end
      end
      e_send: begin
        if (cmd_fire && (sent_cnt_r == 16'(burst_len_p - 1))) begin
          state_n = e_drain;
        end
      end
      e_drain: begin
        if (credits_r == '0) begin
          done    = 1'b1;
          state_n = e_idle;
        end
      end
      default: state_n = e_idle;
    endcase
  end

  // Credit update. An ack with no credits is a protocol error. Such an ack
  // is dropped, so an issue in the same cycle still takes its credit. The
  // zero test looks at the credit count from before this cycle's issue.
  always_comb begin
    credits_n = credits_r;
    if (cmd_fire && (!ack || (credits_r == '0))) begin
      credits_n = credits_r + 1'b1;
    end else if (!cmd_fire && ack && (credits_r != '0)) begin
      credits_n = credits_r - 1'b1;
    end
  end

`ifdef BP_FPGA_HOST_IO_TESTER_CHECK_EN
  // Fields not checked (size, payload) are copied from the received header,
  // so only msg_type, addr and subop can trigger a mismatch.
  bp_bedrock_io_mem_header_s resp_hdr, resp_hdr_exp;
  always_comb begin
    resp_hdr              = io_resp_i[$bits(bp_bedrock_io_mem_header_s)-1:0];
    resp_hdr_exp          = resp_hdr;
    resp_hdr_exp.msg_type = e_bedrock_mem_uc_wr;
    resp_hdr_exp.addr     = putchar_addr_p;
    resp_hdr_exp.subop    = e_bedrock_store;
  end
  assign ack_bad = ack && (resp_hdr != resp_hdr_exp);
`else
  assign ack_bad = 1'b0;
`endif

  logic unused_resp;
  assign unused_resp = ^io_resp_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      byte_r       <= init_byte_p;
      sent_cnt_r   <= '0;
      credits_r    <= '0;
      resp_count_r <= '0;
      error_r      <= 1'b0;
    end else begin
      credits_r <= credits_n;
      if (cmd_fire) begin
        byte_r <= byte_r + 8'd1;
      end
      if (clear_sent) begin
        sent_cnt_r <= '0;
      end else if (cmd_fire) begin
        sent_cnt_r <= sent_cnt_r + 16'd1;
      end
      if (ack) begin
        resp_count_r <= resp_count_r + 16'd1;
      end
      if ((ack && (credits_r == '0)) || ack_bad) begin
        error_r <= 1'b1;
      end
    end
  end

  // The command is built entirely from registers, so it holds steady while
  // it waits for the host.
  bp_bedrock_io_mem_msg_s cmd_msg;
  always_comb begin
    cmd_msg                 = '0;
    cmd_msg.header.msg_type = e_bedrock_mem_uc_wr;
    cmd_msg.header.subop    = e_bedrock_store;
    cmd_msg.header.size     = e_bedrock_msg_size_1;
    cmd_msg.header.addr     = putchar_addr_p;
    cmd_msg.data[7:0]       = byte_r;
  end

  assign io_cmd_o     = io_cmd_v_o ? cmd_msg : '0;
  assign busy_o       = (state_r != e_idle);
  assign done_o       = done;
  assign error_o      = error_r;
  assign resp_count_o = resp_count_r;

  // Loopback FIFO. A single circular buffer serves every depth. With two
  // entries it behaves like a two-element ping-pong buffer: ready means not
  // full, and there is no same-cycle enqueue when full. Read responses carry
  // zero data. Everything else passes through unchanged.
  bp_bedrock_io_mem_msg_s   lb_mem [loopback_els_p];
  bp_bedrock_io_mem_msg_s   lb_entry;
  logic [lb_ptr_w_lp-1:0]   lb_wptr_r, lb_rptr_r;
  logic [lb_cnt_w_lp-1:0]   lb_count_r;
  logic                     lb_full, lb_valid, lb_enq, lb_deq;

  assign lb_full       = (lb_count_r == lb_cnt_w_lp'(loopback_els_p));
  assign lb_valid      = (lb_count_r != '0);
  assign lb_enq        = lb_cmd_v_i & ~lb_full;
  assign lb_deq        = lb_valid & lb_resp_ready_and_i;
  assign lb_cmd_yumi_o = lb_enq;
  assign lb_resp_v_o   = lb_valid;
  assign lb_resp_o     = lb_valid ? lb_mem[lb_rptr_r] : '0;

  always_comb begin
    lb_entry = lb_cmd_i;
    if ((lb_entry.header.msg_type == e_bedrock_mem_rd)
        || (lb_entry.header.msg_type == e_bedrock_mem_uc_rd)) begin
      lb_entry.data = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (lb_enq) begin
      lb_mem[lb_wptr_r] <= lb_entry;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      lb_wptr_r  <= '0;
      lb_rptr_r  <= '0;
      lb_count_r <= '0;
    end else begin
      if (lb_enq) begin
        lb_wptr_r <= (lb_wptr_r == lb_ptr_w_lp'(loopback_els_p - 1)) ? '0 : lb_wptr_r + 1'b1;
      end
      if (lb_deq) begin
        lb_rptr_r <= (lb_rptr_r == lb_ptr_w_lp'(loopback_els_p - 1)) ? '0 : lb_rptr_r + 1'b1;
      end
      if (lb_enq && !lb_deq) begin
        lb_count_r <= lb_count_r + 1'b1;
      end else if (!lb_enq && lb_deq) begin
        lb_count_r <= lb_count_r - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bp_fpga_host_io_tester.sv
// Testbench for bp_fpga_host_io_tester.
//
// A transaction-level model (handshake counters, an expected-byte counter
// and an expected loopback queue) is compared against the DUT on every
// falling clock edge. Directed scenarios then pin the model with literal
// expectations.
module tb_bp_fpga_host_io_tester;
  import bp_fpga_host_io_tester_pkg::*;

  localparam int DB    = 1000;
  localparam int BURST = 16;
  localparam int MAXO  = 4;
  localparam int MW    = io_msg_width_gp;

  logic          clk;
  logic          reset_n_i;
  logic          send_i;
  logic [MW-1:0] io_cmd_o;
  logic          io_cmd_v_o;
  logic          io_cmd_ready_and_i;
  logic [MW-1:0] io_resp_i;
  logic          io_resp_v_i;
  logic          io_resp_yumi_o;
  logic [MW-1:0] lb_cmd_i;
  logic          lb_cmd_v_i;
  logic          lb_cmd_yumi_o;
  logic [MW-1:0] lb_resp_o;
  logic          lb_resp_v_o;
  logic          lb_resp_ready_and_i;
  logic          busy_o, done_o, error_o;
  logic [15:0]   resp_count_o;

  bp_fpga_host_io_tester #(.debounce_cycles_p(DB)) dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .send_i(send_i),
    .io_cmd_o(io_cmd_o), .io_cmd_v_o(io_cmd_v_o), .io_cmd_ready_and_i(io_cmd_ready_and_i),
    .io_resp_i(io_resp_i), .io_resp_v_i(io_resp_v_i), .io_resp_yumi_o(io_resp_yumi_o),
    .lb_cmd_i(lb_cmd_i), .lb_cmd_v_i(lb_cmd_v_i), .lb_cmd_yumi_o(lb_cmd_yumi_o),
    .lb_resp_o(lb_resp_o), .lb_resp_v_o(lb_resp_v_o), .lb_resp_ready_and_i(lb_resp_ready_and_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .resp_count_o(resp_count_o));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model state
  bit         chk_en = 0;
  int         m_sent = 0, m_out = 0, m_done = 0, m_acks = 0;
  logic       m_err = 1'b0;
  logic [7:0] m_byte = 8'h00;
  int         lb_acc = 0, lb_out = 0;
  logic [7:0] wr_log[$];
  logic [7:0] lb_rx_id[$];
  logic [39:0] lb_last_addr;
  logic [63:0] lb_last_data;
  bp_bedrock_io_mem_msg_s lb_q[$];

  // Host controls
  bit ack_enable = 1, rand_ready = 0, inject_ack = 0, lb_active = 0;
  int cyc = 0, issued_seen = 0;
  int ack_q[$];

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bp_bedrock_io_mem_msg_s expCmd(input logic [7:0] b);
    bp_bedrock_io_mem_msg_s m;
    m = '0;
    m.header.msg_type = e_bedrock_mem_uc_wr;
    m.header.subop    = e_bedrock_store;
    m.header.size     = e_bedrock_msg_size_1;
    m.header.addr     = 40'h00_0010_1000;
    m.data            = {56'd0, b};
    return m;
  endfunction

  function automatic bp_bedrock_io_mem_msg_s mkRead(input int idx);
    bp_bedrock_io_mem_msg_s m;
    m = '0;
    m.header.msg_type = e_bedrock_mem_uc_rd;
    m.header.size     = e_bedrock_msg_size_8;
    m.header.addr     = 40'h20;
    m.header.payload  = 8'(idx);
    m.data            = 64'hA5A5_0000_0000_0000 | 64'(idx + 1);
    return m;
  endfunction

  function automatic bp_bedrock_io_mem_msg_s lbExpect(input bp_bedrock_io_mem_msg_s c);
    bp_bedrock_io_mem_msg_s m;
    m = c;
    if (c.header.msg_type == e_bedrock_mem_rd || c.header.msg_type == e_bedrock_mem_uc_rd)
      m.data = '0;
    return m;
  endfunction

  // Per-cycle comparison against the model, then the model advances by the
  // handshakes that complete at the coming rising edge.
  always @(negedge clk) begin
    if (chk_en) begin
      int old_out;
      checkOutput("resp_yumi", io_resp_yumi_o, io_resp_v_i);
      checkOutput("resp_count", resp_count_o, 16'(m_acks));
      checkOutput("error", error_o, m_err);
      if (io_cmd_v_o) begin
        checkOutput("cmd_fields", io_cmd_o, expCmd(m_byte));
        checkOutput("cmd_credit_bound", m_out < MAXO, 1);
        checkOutput("cmd_burst_bound", m_sent < BURST * (m_done + 1), 1);
        checkOutput("busy_during_cmd", busy_o, 1);
      end
      if (done_o)
        checkOutput("done_retire", (m_sent == BURST * (m_done + 1)) && (m_out == 0), 1);
      if (lb_cmd_yumi_o)
        checkOutput("lb_yumi_needs_v", lb_cmd_v_i, 1);
      if (lb_resp_v_o) begin
        if (lb_q.size() == 0) checkOutput("lb_spurious_resp", lb_resp_v_o, 0);
        else                  checkOutput("lb_resp", lb_resp_o, lb_q[0]);
      end
      old_out = m_out;
      if (io_cmd_v_o && io_cmd_ready_and_i) begin
        wr_log.push_back(io_cmd_o[MW-1 -: 64] & 64'hFF);
        m_byte++;
        m_sent++;
        m_out++;
      end
      if (io_resp_v_i) begin
        m_acks++;
        if (old_out == 0) m_err = 1'b1;
        else              m_out--;
      end
      if (done_o) m_done++;
      if (lb_resp_v_o && lb_resp_ready_and_i && lb_q.size() > 0) begin
        bp_bedrock_io_mem_msg_s r;
        r = lb_resp_o;
        lb_rx_id.push_back(r.header.payload);
        lb_last_addr = r.header.addr;
        lb_last_data = r.data;
        void'(lb_q.pop_front());
        lb_out++;
      end
      if (lb_cmd_v_i && lb_cmd_yumi_o) begin
        lb_q.push_back(lbExpect(lb_cmd_i));
        lb_acc++;
      end
    end
  end

  // Host responder: acknowledges each accepted write a few cycles later,
  // optionally withholding acks or throttling ready.
  initial begin
    bp_bedrock_io_mem_msg_s ack_msg;
    ack_msg = expCmd(8'h00);
    io_resp_i = ack_msg;
    io_resp_v_i = 1'b0;
    io_cmd_ready_and_i = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      while (issued_seen < m_sent) begin
        ack_q.push_back(cyc + 2);
        issued_seen++;
      end
      if (ack_enable && ack_q.size() > 0 && ack_q[0] <= cyc) begin
        io_resp_v_i = 1'b1;
        void'(ack_q.pop_front());
      end else begin
        io_resp_v_i = inject_ack;
      end
      io_cmd_ready_and_i = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Drives the button level for a number of cycles. The loopback stream
  // runs alongside when it is enabled.
  task automatic applyStimulus(input logic level, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      send_i = level;
      if (lb_active && lb_acc < 10) begin
        lb_cmd_v_i = 1'b1;
        lb_cmd_i   = mkRead(lb_acc);
      end else begin
        lb_cmd_v_i = 1'b0;
      end
      lb_resp_ready_and_i = lb_active ? ~lb_resp_ready_and_i : 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitBurst(input int target);
    int n = 0;
    while (m_done < target && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("burst_done_count", m_done, target);
    checkOutput("idle_after_burst", busy_o, 0);
  endtask

  task automatic runBurst(input int target);
    applyStimulus(1'b1, DB + 10);
    applyStimulus(1'b0, DB + 10);
    waitBurst(target);
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    reset_n_i = 1'b0;
    send_i = 1'b0;
    lb_cmd_i = '0;
    lb_cmd_v_i = 1'b0;
    lb_resp_ready_and_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_done", done_o, 0);
    checkOutput("rst_error", error_o, 0);
    checkOutput("rst_resp_count", resp_count_o, 0);
    checkOutput("rst_cmd_v", io_cmd_v_o, 0);
    checkOutput("rst_cmd", io_cmd_o, 0);
    checkOutput("rst_lb_resp_v", lb_resp_v_o, 0);
    checkOutput("rst_lb_resp", lb_resp_o, 0);
    checkOutput("rst_lb_yumi", lb_cmd_yumi_o, 0);
    reset_n_i = 1'b1;
    chk_en = 1;

    // Bouncing button: never stable long enough, so nothing issues.
    for (int k = 0; k < 10; k++) applyStimulus(k % 2 == 0, 100);
    applyStimulus(1'b0, DB + 10);
    checkOutput("bounce_no_writes", m_sent, 0);
    checkOutput("bounce_no_done", m_done, 0);
    checkOutput("bounce_idle", busy_o, 0);

    // Burst 1: always ready, acks a few cycles later.
    runBurst(1);
    checkOutput("b1_write_count", wr_log.size(), 16);
    checkOutput("b1_first_byte", wr_log[0], 8'h00);
    checkOutput("b1_last_byte", wr_log[15], 8'h0F);
    checkOutput("b1_resp_count", resp_count_o, 16'd16);
    checkOutput("b1_error", error_o, 0);

    // Burst 2: acks withheld, so only four writes may be outstanding.
    ack_enable = 0;
    applyStimulus(1'b1, DB + 10);
    applyStimulus(1'b0, 100);
    checkOutput("withhold_sent", m_sent, 20);
    checkOutput("withhold_cmd_v", io_cmd_v_o, 0);
    checkOutput("withhold_busy", busy_o, 1);
    ack_enable = 1;
    applyStimulus(1'b0, DB);
    waitBurst(2);

    // Burst 3 with a concurrent loopback stream and a toggling response ready.
    applyStimulus(1'b1, DB - 20);
    lb_active = 1;
    applyStimulus(1'b1, 30);
    applyStimulus(1'b0, 200);
    lb_active = 0;
    n = 0;
    while (lb_out < 10 && n < 500) begin
      applyStimulus(1'b0, 1);
      n++;
    end
    applyStimulus(1'b0, DB);
    waitBurst(3);
    checkOutput("lb_count", lb_out, 10);
    checkOutput("lb_first_id", lb_rx_id[0], 8'd0);
    checkOutput("lb_last_id", lb_rx_id[9], 8'd9);
    checkOutput("lb_addr", lb_last_addr, 40'h20);
    checkOutput("lb_data_zero", lb_last_data, 64'h0);

    // Bursts 4..17 with a throttled host: the byte counter wraps.
    rand_ready = 1;
    for (int b = 4; b <= 17; b++) runBurst(b);
    rand_ready = 0;
    checkOutput("wrap_total_writes", wr_log.size(), 272);
    checkOutput("wrap_byte_ff", wr_log[255], 8'hFF);
    checkOutput("wrap_byte_00", wr_log[256], 8'h00);
    checkOutput("wrap_resp_count", resp_count_o, 16'd272);
    checkOutput("wrap_no_error", error_o, 0);

    // Unsolicited ack while idle: sticky error.
    applyStimulus(1'b0, 5);
    inject_ack = 1;
    applyStimulus(1'b0, 1);
    inject_ack = 0;
    applyStimulus(1'b0, 50);
    checkOutput("idle_ack_error", error_o, 1);
    checkOutput("idle_ack_count", resp_count_o, 16'd273);

    // Asynchronous reset clears everything without waiting for a clock edge.
    chk_en = 0;
    @(posedge clk);
    #3;
    reset_n_i = 1'b0;
    #1;
    checkOutput("async_rst_error", error_o, 0);
    checkOutput("async_rst_count", resp_count_o, 0);
    checkOutput("async_rst_busy", busy_o, 0);
    @(posedge clk);
    #1;
    reset_n_i = 1'b1;
    applyStimulus(1'b0, 5);
    checkOutput("post_rst_error", error_o, 0);
    checkOutput("post_rst_cmd_v", io_cmd_v_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
